// File: rtl/rs232_frame_parser.sv
// RS232 command frame parser: A5, cmd, 4 payload bytes (MSB first), XOR checksum.
// Define FRAME_STATS_EN to add saturating good/bad frame counters.
`default_nettype none

module rs232_frame_parser #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter logic [7:0] CMD_GPIO       = 8'h01,
    parameter logic [7:0] CMD_SNR        = 8'h02,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter int          TO_W           = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] rx_data,
    output logic        gpio_start,
    output logic        snr_start,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic [7:0]      r_chk;
    logic [1:0]      r_idx;
    logic [7:0]      r_cmd;
    logic [31:0]     r_shadow;
    logic [31:0]     r_rx_data;
    logic            r_gpio;
    logic            r_snr;
    logic            r_err;
    logic [1:0]      r_code;
    logic            r_busy;

    logic w_cmd_ok;
    logic w_chk_ok;
    logic w_expire;
    logic w_good;

    assign w_cmd_ok = (byte_data == CMD_GPIO) || (byte_data == CMD_SNR);
    assign w_chk_ok = (byte_data == r_chk);
    assign w_expire = !byte_valid && (r_state != IDLE) && (r_cnt == TO_MAX);
    assign w_good   = byte_valid && (r_state == CHK) && w_chk_ok;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_chk     <= '0;
            r_idx     <= '0;
            r_cmd     <= '0;
            r_shadow  <= '0;
            r_rx_data <= '0;
            r_gpio    <= 1'b0;
            r_snr     <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_gpio <= 1'b0;
            r_snr  <= 1'b0;
            r_err  <= 1'b0;
            if (byte_valid) begin
                // any accepted byte restarts the inter-byte window
                r_cnt <= '0;
                unique case (r_state)
                    IDLE: begin
                        if (byte_data == HEADER) begin
                            r_state <= CMD;
                            r_chk   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (w_cmd_ok) begin
                            r_cmd   <= byte_data;
                            r_chk   <= byte_data;
                            r_idx   <= '0;
                            r_state <= PAYLOAD;
                        end else begin
                            r_err   <= 1'b1;
                            r_code  <= 2'd1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    PAYLOAD: begin
                        r_shadow <= {r_shadow[23:0], byte_data};
                        r_chk    <= r_chk ^ byte_data;
                        r_idx    <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= CHK;
                        end
                    end
                    CHK: begin
                        if (w_good) begin
                            r_rx_data <= r_shadow;
                            r_gpio    <= (r_cmd == CMD_GPIO);
                            r_snr     <= (r_cmd == CMD_SNR);
                        end else begin
                            r_err  <= 1'b1;
                            r_code <= 2'd2;
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_state != IDLE) begin
                if (w_expire) begin
                    r_err   <= 1'b1;
                    r_code  <= 2'd3;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign gpio_start = r_gpio;
    assign snr_start  = r_snr;
    assign frame_err  = r_err;
    assign err_code   = r_code;
    assign busy       = r_busy;

`ifdef FRAME_STATS_EN
    logic        w_bad;
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    assign w_bad = w_expire ||
                   (byte_valid && (r_state == CMD) && !w_cmd_ok) ||
                   (byte_valid && (r_state == CHK) && !w_chk_ok);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            if (w_good && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_bad && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs232_frame_parser.sv
// Scoreboard bench for rs232_frame_parser: frame-level model, random frames,
// expected pulses queued by the driver and matched by a negedge monitor.
`timescale 1ns/1ps

module tb_rs232_frame_parser;

    localparam int TO = 64;
    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [2:0] K_G = 3'b100;
    localparam logic [2:0] K_S = 3'b010;
    localparam logic [2:0] K_E = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bv = 1'b0;
    logic [7:0]  bd = 8'h00;
    logic [31:0] rx;
    logic        g, s, e, busy;
    logic [1:0]  code;
`ifdef FRAME_STATS_EN
    logic [15:0] gc, bc;
`endif

    always #5 clk = ~clk;

    rs232_frame_parser #(
        .TIMEOUT_CYCLES(TO),
        .TO_W(16)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst_n),
        .byte_valid(bv),
        .byte_data(bd),
        .rx_data(rx),
        .gpio_start(g),
        .snr_start(s),
        .frame_err(e),
        .err_code(code),
        .busy(busy)
`ifdef FRAME_STATS_EN
        ,
        .good_cnt(gc),
        .bad_cnt(bc)
`endif
    );

    typedef struct {
        logic [2:0]  k;
        logic [31:0] d;
        logic [1:0]  c;
        longint      at;
    } ev_t;

    ev_t q[$];
    ev_t mon_ev;
    int n_tot = 0;
    int n_pass = 0;
    longint cyc = 0;
    logic [31:0] m_rx = 0;
    logic [1:0] m_code = 0;
    int m_good = 0;
    int m_bad = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // monitor: any pulse must match the head of the queue at its cycle
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].at < cyc) begin
            chk("missing_pulse", cyc, q[0].at);
            void'(q.pop_front());
        end
        if (g || s || e) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {61'd0, g, s, e}, 64'd0);
            end else begin
                mon_ev = q.pop_front();
                chk("pulse_kind", {61'd0, g, s, e}, {61'd0, mon_ev.k});
                chk("pulse_cycle", cyc, mon_ev.at);
                chk("rx_data", {32'd0, rx}, {32'd0, mon_ev.d});
                chk("err_code", {62'd0, code}, {62'd0, mon_ev.c});
                chk("busy_after", {63'd0, busy}, 64'd0);
`ifdef FRAME_STATS_EN
                if (mon_ev.k == K_E) m_bad++;
                else m_good++;
                chk("good_cnt", {48'd0, gc}, m_good);
                chk("bad_cnt", {48'd0, bc}, m_bad);
`endif
            end
        end
    end

    task automatic put(input bit v, input logic [7:0] d);
        bv = v;
        bd = d;
        @(posedge clk);
        #1;
        bv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        put(1'b1, b);
    endtask

    task automatic push(input logic [2:0] k, input logic [31:0] d,
                        input logic [1:0] c, input longint at);
        ev_t x;
        x.k = k;
        x.d = d;
        x.c = c;
        x.at = at;
        q.push_back(x);
    endtask

    function automatic logic [7:0] fbyte(input logic [7:0] cmd,
                                         input logic [31:0] p,
                                         input int i);
        logic [7:0] r;
        case (i)
            0: r = HDR;
            1: r = cmd;
            2: r = p[31:24];
            3: r = p[23:16];
            4: r = p[15:8];
            5: r = p[7:0];
            default: r = cmd ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
        endcase
        return r;
    endfunction

    // long_at: index of the byte that arrives after exactly TO idle cycles
    task automatic frame(input logic [7:0] cmd, input logic [31:0] p,
                         input logic [7:0] bad_mask, input int long_at);
        int gap;
        logic [7:0] b;
        for (int i = 0; i < 7; i++) begin
            gap = (i == 0) ? 0 : (i == long_at) ? TO : $urandom_range(0, 2);
            b = fbyte(cmd, p, i);
            if (i == 6) b = b ^ bad_mask;
            send(b, gap);
            if (i == 0) chk("busy_on_hdr", {63'd0, busy}, 64'd1);
        end
        if (bad_mask == 8'h00) begin
            push((cmd == 8'h01) ? K_G : K_S, p, m_code, cyc);
            m_rx = p;
        end else begin
            push(K_E, m_rx, 2'd2, cyc);
            m_code = 2'd2;
        end
    endtask

    task automatic bad_cmd(input logic [7:0] c);
        send(HDR, 0);
        send(c, $urandom_range(0, 2));
        push(K_E, m_rx, 2'd1, cyc);
        m_code = 2'd1;
    endtask

    task automatic prefix(input int n, input logic [7:0] cmd,
                          input logic [31:0] p);
        for (int i = 0; i < n; i++) send(fbyte(cmd, p, i), $urandom_range(0, 2));
    endtask

    task automatic timeout(input int n, input logic [7:0] cmd,
                           input logic [31:0] p);
        prefix(n, cmd, p);
        push(K_E, m_rx, 2'd3, cyc + TO + 1);
        m_code = 2'd3;
        idle(TO + 1);
        chk("busy_after_to", {63'd0, busy}, 64'd0);
    endtask

    task automatic reset_mid(input int n, input logic [7:0] cmd,
                             input logic [31:0] p);
        prefix(n, cmd, p);
        rst_n = 1'b0;
        put(1'b0, 8'h00);
        rst_n = 1'b1;
        m_rx = 0;
        m_code = 0;
        m_good = 0;
        m_bad = 0;
        chk("rst_rx", {32'd0, rx}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_code", {62'd0, code}, 64'd0);
    endtask

    task automatic noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == HDR) b = 8'h00;
            send(b, $urandom_range(0, 3));
        end
    endtask

    function automatic logic [7:0] rcmd();
        return ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
    endfunction

    function automatic logic [7:0] rbadcmd();
        logic [7:0] c;
        c = 8'($urandom);
        if (c == 8'h01 || c == 8'h02) c = 8'h03;
        return c;
    endfunction

    initial begin
        idle(3);
        rst_n = 1'b1;
        chk("reset_rx", {32'd0, rx}, 64'd0);
        chk("reset_pulses", {61'd0, g, s, e}, 64'd0);
        chk("reset_code", {62'd0, code}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);

        reset_mid(5, 8'h01, 32'h12345678);
        frame(8'h01, 32'h12345678, 8'h00, -1);
`ifdef FRAME_STATS_EN
        chk("stats_good_after_rst", {48'd0, gc}, 64'd1);
        chk("stats_bad_after_rst", {48'd0, bc}, 64'd0);
`endif
        frame(8'h02, 32'h000000FF, 8'h00, -1);
        frame(8'h01, 32'h12345678, 8'h03, -1);
        bad_cmd(8'h03);
        frame(8'h01, 32'hCAFEF00D, 8'h00, -1);
        bad_cmd(HDR);
        timeout(3, 8'h01, 32'h12345678);
        send(8'h34, 0);
        frame(8'h01, 32'h12345678, 8'h00, 3);
        frame(8'h02, 32'hDEADBEEF, 8'h00, 6);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 7))
                0, 1: frame(rcmd(), $urandom, 8'h00, -1);
                2: frame(rcmd(), $urandom, 8'h00, $urandom_range(1, 6));
                3: frame(rcmd(), $urandom, 8'($urandom_range(1, 255)), -1);
                4: bad_cmd(rbadcmd());
                5: timeout($urandom_range(1, 6), rcmd(), $urandom);
                6: noise($urandom_range(1, 5));
                default: reset_mid($urandom_range(1, 6), rcmd(), $urandom);
            endcase
        end

        idle(5);
        chk("queue_empty", q.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
